mp_banked_sram: RTL and testbench



---
 rtl/mp_banked_sram.sv | 199 +++++++++++++++++++
 tb/tb_mp_banked_sram.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mp_banked_sram.sv
// Multi-port SRAM over word-interleaved single-port banks with per-bank
// round-robin arbitration; read data returns 1 + OutRegs cycles after grant.
module mp_banked_sram #(
  parameter int unsigned NrPorts   = 2,
  parameter int unsigned NumBanks  = 4,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned OutRegs   = 0,
  parameter int unsigned AddrWidth = $clog2(NumWords)
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NrPorts-1:0]                         req_i,
  input  logic [NrPorts-1:0]                         we_i,
  input  logic [NrPorts-1:0][AddrWidth-1:0]          addr_i,
  input  logic [NrPorts-1:0][DataWidth-1:0]          wdata_i,
  input  logic [NrPorts-1:0][(DataWidth+7)/8-1:0]    be_i,
  output logic [NrPorts-1:0]                         gnt_o,
  output logic [NrPorts-1:0]                         rvalid_o,
  output logic [NrPorts-1:0][DataWidth-1:0]          rdata_o
);

  localparam int unsigned LogBanks  = $clog2(NumBanks);
  localparam int unsigned BankW     = (NumBanks > 1) ? LogBanks : 1;
  localparam int unsigned RowWidth  = AddrWidth - LogBanks;
  localparam int unsigned BankWords = NumWords / NumBanks;
  localparam int unsigned PortW     = (NrPorts > 1) ? $clog2(NrPorts) : 1;
  localparam int unsigned BeW       = (DataWidth + 7) / 8;

  function automatic logic [DataWidth-1:0] be_to_mask(input logic [BeW-1:0] be);
    logic [DataWidth-1:0] m;
    m = '0;
    for (int j = 0; j < DataWidth; j++) begin
      m[j] = be[j/8];
    end
    return m;
  endfunction

  logic [NrPorts-1:0][BankW-1:0]     bank_sel;
  logic [NrPorts-1:0][RowWidth-1:0]  row_sel;

  for (genvar p = 0; p < NrPorts; p++) begin : g_dec
    if (NumBanks > 1) begin : g_multi
      assign bank_sel[p] = addr_i[p][LogBanks-1:0];
      assign row_sel[p]  = addr_i[p][AddrWidth-1:LogBanks];
    end else begin : g_single
      assign bank_sel[p] = '0;
      assign row_sel[p]  = addr_i[p];
    end
  end

  // Arbitration: each bank scans ports starting one past its last winner.
  logic [NumBanks-1:0][PortW-1:0] rr_q;
  logic [NumBanks-1:0][PortW-1:0] win;
  logic [NumBanks-1:0]            bank_act;
  logic [NumBanks-1:0]            bank_go;
  logic [NrPorts-1:0]             gnt;

  always_comb begin
    logic [PortW-1:0] idx;
    gnt      = '0;
    bank_act = '0;
    win      = rr_q;
    idx      = '0;
    for (int b = 0; b < NumBanks; b++) begin
      for (int i = 1; i <= NrPorts; i++) begin
        idx = PortW'((int'(rr_q[b]) + i) % int'(NrPorts));
        if (!bank_act[b] && req_i[idx] && (bank_sel[idx] == BankW'(b))) begin
          bank_act[b] = 1'b1;
          win[b]      = idx;
          gnt[idx]    = 1'b1;
        end
      end
    end
  end

  assign gnt_o   = rst_i ? '0 : gnt;
  assign bank_go = rst_i ? '0 : bank_act;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NumBanks; b++) begin
        rr_q[b] <= PortW'(NrPorts - 1);
      end
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        if (bank_go[b]) begin
          rr_q[b] <= win[b];
        end
      end
    end
  end

  logic [NumBanks-1:0]                bank_we;
  logic [NumBanks-1:0][RowWidth-1:0]  bank_row;
  logic [NumBanks-1:0][DataWidth-1:0] bank_wdata;
  logic [NumBanks-1:0][DataWidth-1:0] bank_mask;
  logic [NumBanks-1:0][DataWidth-1:0] bank_rdata;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    logic [DataWidth-1:0] mem [BankWords];
    logic [DataWidth-1:0] rd_q;

    assign bank_we[b]    = we_i[win[b]];
    assign bank_row[b]   = row_sel[win[b]];
    assign bank_wdata[b] = wdata_i[win[b]];
    assign bank_mask[b]  = be_to_mask(be_i[win[b]]);
    assign bank_rdata[b] = rd_q;

    // Bank access stage: one winner per bank, read or byte-masked write.
    always_ff @(posedge clk_i) begin
      if (bank_go[b]) begin
        if (bank_we[b]) begin
          mem[bank_row[b]] <= (mem[bank_row[b]] & ~bank_mask[b]) |
                              (bank_wdata[b] & bank_mask[b]);
        end else begin
          rd_q <= mem[bank_row[b]];
        end
      end
    end
  end

  // Return stage p0: route each port's bank read data back to the port.
  logic [NrPorts-1:0]                vld_p0;
  logic [NrPorts-1:0][BankW-1:0]     bank_p0;
  logic [NrPorts-1:0][DataWidth-1:0] rdata_sel;
  logic [NrPorts-1:0][DataWidth-1:0] rdata_p1;

  always_comb begin
    rdata_sel = '0;
    for (int p = 0; p < NrPorts; p++) begin
      rdata_sel[p] = bank_rdata[bank_p0[p]];
    end
  end

  always_ff @(posedge clk_i) begin
    bank_p0 <= bank_sel;
  end

  // rdata_p1 is both the optional output register and the hold value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p0   <= '0;
      rdata_p1 <= '0;
    end else begin
      vld_p0 <= gnt_o & ~we_i;
      for (int p = 0; p < NrPorts; p++) begin
        if (vld_p0[p]) begin
          rdata_p1[p] <= rdata_sel[p];
        end
      end
    end
  end

  if (OutRegs != 0) begin : g_oreg
    logic [NrPorts-1:0] vld_p1;
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_p1 <= '0;
      end else begin
        vld_p1 <= vld_p0;
      end
    end
    assign rvalid_o = vld_p1;
    assign rdata_o  = rdata_p1;
  end else begin : g_noreg
    always_comb begin
      rdata_o = rdata_p1;
      for (int p = 0; p < NrPorts; p++) begin
        if (vld_p0[p]) begin
          rdata_o[p] = rdata_sel[p];
        end
      end
    end
    assign rvalid_o = vld_p0;
  end

  logic [NrPorts-1:0] pend_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= req_i & ~gnt_o;
    end
  end

  always @(posedge clk_i) begin
    assert ((NumWords % NumBanks) == 0) else $error("NumWords not a multiple of NumBanks");
    assert ((NumWords & (NumWords - 1)) == 0) else $error("NumWords not a power of two");
    assert ((NumBanks & (NumBanks - 1)) == 0) else $error("NumBanks not a power of two");
    if (!rst_i) begin
      for (int p = 0; p < NrPorts; p++) begin
        assert (!pend_q[p] || req_i[p]) else $error("port %0d dropped request before grant", p);
      end
    end
  end

endmodule

// File: tb/tb_mp_banked_sram.sv
// Directed bench for mp_banked_sram: one instance without and one with the
// output register, both driven by the same ports.
module tb_mp_banked_sram;

  logic              clk;
  logic              rst;
  logic [1:0]        req;
  logic [1:0]        we;
  logic [1:0][9:0]   addr;
  logic [1:0][63:0]  wdata;
  logic [1:0][7:0]   be;
  logic [1:0]        gnt0, gnt1;
  logic [1:0]        rvalid0, rvalid1;
  logic [1:0][63:0]  rdata0, rdata1;

  int passed = 0;
  int total  = 0;

  localparam logic [63:0] V5  = 64'hDEAD_BEEF_0000_1111;
  localparam logic [63:0] V1  = 64'h1111_0000_0000_0001;
  localparam logic [63:0] V2  = 64'hA2A2_A2A2_0202_0202;
  localparam logic [63:0] V3  = 64'hB3B3_B3B3_0303_0303;
  localparam logic [63:0] V7  = 64'h7777_0000_7777_0007;

  mp_banked_sram #(.NrPorts(2), .NumBanks(4), .DataWidth(64), .NumWords(1024), .OutRegs(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0)
  );

  mp_banked_sram #(.NrPorts(2), .NumBanks(4), .DataWidth(64), .NumWords(1024), .OutRegs(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be),
    .gnt_o(gnt1), .rvalid_o(rvalid1), .rdata_o(rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic r, input logic w, input logic [9:0] a,
                       input logic [63:0] d, input logic [7:0] b);
    req[p]   = r;
    we[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    be[p]    = b;
  endtask

  initial begin
    rst = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    tick();
    tick();
    // Grants suppressed during reset, outputs cleared.
    drive(0, 1'b1, 1'b0, 10'd0, 64'd0, 8'h00);
    drive(1, 1'b1, 1'b0, 10'd1, 64'd0, 8'h00);
    #1;
    check("reset_gnt0", 64'(gnt0), 64'd0);
    check("reset_gnt1", 64'(gnt1), 64'd0);
    check("reset_rvalid0", 64'(rvalid0), 64'd0);
    check("reset_rvalid1", 64'(rvalid1), 64'd0);
    check("reset_rdata0", rdata0[0], 64'd0);
    check("reset_rdata1", rdata1[1], 64'd0);
    tick();
    rst = 1'b0;
    req = '0;

    // Full write then read of addr 5 on port 0.
    drive(0, 1'b1, 1'b1, 10'd5, V5, 8'hFF);
    #1;
    check("wr5_gnt", 64'(gnt0), 64'd1);
    tick();
    drive(0, 1'b1, 1'b0, 10'd5, 64'd0, 8'h00);
    #1;
    check("rd5_gnt", 64'(gnt0), 64'd1);
    check("wr_no_rvalid", 64'(rvalid0), 64'd0);
    tick();
    req = '0;
    #1;
    check("rd5_rvalid0", 64'(rvalid0), 64'd1);
    check("rd5_rdata0", rdata0[0], V5);
    check("rd5_oreg_early", 64'(rvalid1), 64'd0);
    tick();
    check("rd5_rvalid1", 64'(rvalid1), 64'd1);
    check("rd5_rdata1", rdata1[0], V5);
    check("rd5_rvalid0_low", 64'(rvalid0), 64'd0);
    check("rd5_rdata0_hold", rdata0[0], V5);

    // Partial write with low byte enables.
    drive(0, 1'b1, 1'b1, 10'd8, 64'd0, 8'hFF);
    tick();
    drive(0, 1'b1, 1'b1, 10'd8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    tick();
    drive(0, 1'b1, 1'b0, 10'd8, 64'd0, 8'h00);
    tick();
    req = '0;
    #1;
    check("part_rvalid", 64'(rvalid0), 64'd1);
    check("part_rdata", rdata0[0], 64'h0000_0000_FFFF_FFFF);

    // Parallel access to banks 2 and 3.
    drive(0, 1'b1, 1'b1, 10'd2, V2, 8'hFF);
    drive(1, 1'b1, 1'b1, 10'd3, V3, 8'hFF);
    #1;
    check("par_wr_gnt", 64'(gnt0), 64'd3);
    tick();
    drive(0, 1'b1, 1'b0, 10'd2, 64'd0, 8'h00);
    drive(1, 1'b1, 1'b0, 10'd3, 64'd0, 8'h00);
    #1;
    check("par_rd_gnt", 64'(gnt0), 64'd3);
    tick();
    req = '0;
    #1;
    check("par_rvalid", 64'(rvalid0), 64'd3);
    check("par_rdata_p0", rdata0[0], V2);
    check("par_rdata_p1", rdata0[1], V3);

    // Preload addr 1 and 7, then read 7 to observe the two-cycle path.
    drive(0, 1'b1, 1'b1, 10'd1, V1, 8'hFF);
    tick();
    drive(0, 1'b1, 1'b1, 10'd7, V7, 8'hFF);
    tick();
    drive(0, 1'b1, 1'b0, 10'd7, 64'd0, 8'h00);
    #1;
    check("oreg_gnt", 64'(gnt1), 64'd1);
    tick();
    req = '0;
    #1;
    check("oreg_t1_rvalid1", 64'(rvalid1), 64'd0);
    check("oreg_t1_rvalid0", 64'(rvalid0), 64'd1);
    tick();
    check("oreg_t2_rvalid1", 64'(rvalid1), 64'd1);
    check("oreg_t2_rdata1", rdata1[0], V7);
    tick();
    check("oreg_t3_rvalid1", 64'(rvalid1), 64'd0);

    // Conflict on bank 1 after reset: strict alternation starting at port 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 10'd1, 64'd0, 8'h00);
    drive(1, 1'b1, 1'b0, 10'd5, 64'd0, 8'h00);
    #1;
    check("cf_c1_gnt", 64'(gnt0), 64'd1);
    tick();
    check("cf_c2_gnt", 64'(gnt0), 64'd2);
    check("cf_c2_rvalid", 64'(rvalid0), 64'd1);
    check("cf_c2_rdata", rdata0[0], V1);
    tick();
    check("cf_c3_gnt", 64'(gnt0), 64'd1);
    check("cf_c3_rvalid", 64'(rvalid0), 64'd2);
    check("cf_c3_rdata", rdata0[1], V5);
    check("cf_c3_rvalid1", 64'(rvalid1), 64'd1);
    tick();
    check("cf_c4_gnt", 64'(gnt0), 64'd2);
    check("cf_c4_rvalid", 64'(rvalid0), 64'd1);
    tick();
    req[1] = 1'b0;
    #1;
    check("cf_c5_single_gnt", 64'(gnt0), 64'd1);
    check("cf_c5_rvalid", 64'(rvalid0), 64'd2);
    tick();
    req = '0;
    #1;
    check("cf_c6_rvalid", 64'(rvalid0), 64'd1);
    check("cf_c6_rdata", rdata0[0], V1);

    // Reset one cycle after a read grant: in-flight read dropped.
    tick();
    drive(0, 1'b1, 1'b0, 10'd7, 64'd0, 8'h00);
    #1;
    check("rm_gnt", 64'(gnt1), 64'd1);
    tick();
    rst = 1'b1;
    drive(0, 1'b1, 1'b0, 10'd2, 64'd0, 8'h00);
    drive(1, 1'b1, 1'b0, 10'd3, 64'd0, 8'h00);
    #1;
    check("rm_gnt_in_reset", 64'(gnt0), 64'd0);
    tick();
    check("rm_rvalid1", 64'(rvalid1), 64'd0);
    check("rm_rvalid0", 64'(rvalid0), 64'd0);
    check("rm_rdata0", rdata0[0], 64'd0);
    check("rm_rdata1", rdata1[0], 64'd0);
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 10'd1, 64'd0, 8'h00);
    drive(1, 1'b1, 1'b0, 10'd5, 64'd0, 8'h00);
    #1;
    check("rm_after_gnt", 64'(gnt0), 64'd1);
    check("rm_after_rvalid1", 64'(rvalid1), 64'd0);
    tick();
    req[0] = 1'b0;
    #1;
    check("rm_after_p1_gnt", 64'(gnt0), 64'd2);
    tick();
    req = '0;
    tick();
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
